// File: rtl/config_shift_sequencer_pkg.sv
// Shared fabric configuration package: default geometry and the sequencer state encoding.
package config_shift_sequencer_pkg;

  localparam int unsigned DEF_NCOL   = 4;
  localparam int unsigned DEF_WORD_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SET   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/config_shift_sequencer_serializer.sv
// Word register, bit index and remaining-bit counter feeding the serial config stream LSB first.
module cfg_word_serializer
  import config_shift_sequencer_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [CNT_W-1:0]  nbits_i,
  input  logic              accept_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              step_i,
  output logic              next_bit_c_o,
  output logic              word_end_c_o,
  output logic              final_bit_c_o
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    rem_d  = rem_q;
    if (load_i) begin
      rem_d = nbits_i;
    end
    if (accept_i) begin
      word_d = word_i;
      idx_d  = '0;
    end else if (step_i) begin
      word_d = word_q >> 1;
      idx_d  = idx_q + IDX_W'(1);
      rem_d  = rem_q - CNT_W'(1);
    end
  end

  // Bit presented on the cycle after this one: first bit of a fresh word, else the next shifted bit.
  assign next_bit_c_o  = accept_i ? word_i[0] : word_q[1];
  assign final_bit_c_o = (rem_q == CNT_W'(1));
  assign word_end_c_o  = final_bit_c_o || (idx_q == IDX_W'(WORD_W - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      idx_q  <= '0;
      rem_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/config_shift_sequencer.sv
// Loads one fabric configuration column from a bitstream word stream: LOAD/SHIFT per word, then SET and DONE.
module config_shift_sequencer
  import config_shift_sequencer_pkg::*;
#(
  parameter int unsigned NCOL   = DEF_NCOL,
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  localparam int unsigned COL_W = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [COL_W-1:0]  col_i,
  input  logic [CNT_W-1:0]  nbits_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              cfg_bit_o,
  output logic [NCOL-1:0]   shift_o,
  output logic [NCOL-1:0]   set_o,
  output logic [NCOL-1:0]   cen_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  seq_state_e        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [NCOL-1:0]   col_oh;
  logic [NCOL-1:0]   shift_q, shift_d, set_q, set_d, cen_q, cen_d;
  logic              ready_q, ready_d, bit_q, bit_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              start_ok, handshake;
  logic              ser_load, ser_accept, ser_step;
  logic              next_bit, word_end, final_bit;

  assign start_ok  = (32'(col_i) < NCOL) && (nbits_i != '0);
  assign handshake = word_valid_i && ready_q;

  cfg_word_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_serializer (
    .clk_i         (wb_clk_i),
    .rst_ni        (wb_rst_ni),
    .load_i        (ser_load),
    .nbits_i       (nbits_i),
    .accept_i      (ser_accept),
    .word_i        (word_i),
    .step_i        (ser_step),
    .next_bit_c_o  (next_bit),
    .word_end_c_o  (word_end),
    .final_bit_c_o (final_bit)
  );

  // Next state, serializer control and next-cycle output values.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    ser_load   = 1'b0;
    ser_accept = 1'b0;
    ser_step   = 1'b0;
    err_d      = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (start_ok) begin
            state_d  = ST_LOAD;
            col_d    = col_i;
            ser_load = 1'b1;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        ser_accept = handshake;
        if (handshake) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_step = 1'b1;
        if (word_end) state_d = final_bit ? ST_SET : ST_LOAD;
      end
      ST_SET:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over everything; a word handshaken in the same cycle is still consumed.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      ser_step = 1'b0;
      err_d    = 1'b1;
    end
    if (state_d == ST_DONE) done_d = 1'b1;

    col_oh = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      col_oh[c] = (32'(col_d) == c);
    end
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_LOAD);
    cen_d   = (state_d inside {ST_LOAD, ST_SHIFT, ST_SET}) ? col_oh : '0;
    shift_d = (state_d == ST_SHIFT) ? col_oh : '0;
    set_d   = (state_d == ST_SET) ? col_oh : '0;
    bit_d   = (state_d == ST_SHIFT) && next_bit;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      ready_q <= 1'b0;
      bit_q   <= 1'b0;
      shift_q <= '0;
      set_q   <= '0;
      cen_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      ready_q <= ready_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      set_q   <= set_d;
      cen_q   <= cen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign word_ready_o = ready_q;
  assign cfg_bit_o    = bit_q;
  assign shift_o      = shift_q;
  assign set_o        = set_q;
  assign cen_o        = cen_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_config_shift_sequencer.sv
// Table-driven bench for config_shift_sequencer with a bit scoreboard and hand-written reset sequence.
module tb_config_shift_sequencer;

  localparam int NCOL   = 5;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;
  localparam int COL_W  = $clog2(NCOL);

  typedef struct {
    int          col;
    int          nbits;
    logic [31:0] w0;
    logic [31:0] w1;
    int          stall;
    int          abort_at;
    int          exp_busy;
    bit          exp_err;
    bit          exp_set;
  } vec_t;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [COL_W-1:0]  col_i = '0;
  logic [CNT_W-1:0]  nbits_i = '0;
  logic [WORD_W-1:0] word_i = '0;
  logic              word_valid_i = 1'b0;
  logic              word_ready_o, cfg_bit_o, busy_o, done_o, err_o;
  logic [NCOL-1:0]   shift_o, set_o, cen_o;

  int n_checks = 0;
  int n_err    = 0;
  bit exp_q[$];
  vec_t vecs[8];

  config_shift_sequencer #(
    .NCOL   (NCOL),
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_ni    (wb_rst_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .col_i        (col_i),
    .nbits_i      (nbits_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .cfg_bit_o    (cfg_bit_o),
    .shift_o      (shift_o),
    .set_o        (set_o),
    .cen_o        (cen_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check_quiet(input string name);
    check(name, {cfg_bit_o, shift_o, set_o, cen_o, busy_o, done_o, err_o, word_ready_o}, 64'd0);
  endtask

  task automatic run_txn(input vec_t v);
    int busy_cnt, shift_cnt, set_cnt, done_cnt, bits_left, stall_left, wi, take, exp_shift;
    bit invalid;
    logic [NCOL-1:0] exp_oh;
    logic [31:0] w;
    busy_cnt = 0; shift_cnt = 0; set_cnt = 0; done_cnt = 0; wi = 0;
    invalid    = (v.col >= NCOL) || (v.nbits == 0);
    exp_oh     = invalid ? '0 : (NCOL'(1) << v.col);
    bits_left  = v.nbits;
    stall_left = v.stall;
    exp_q.delete();

    start_i = 1'b1; col_i = COL_W'(v.col); nbits_i = CNT_W'(v.nbits);
    tick();
    start_i = 1'b0; col_i = '0; nbits_i = '0;

    for (int cyc = 0; cyc < 400 && busy_o; cyc++) begin
      busy_cnt++;
      check("err_while_busy", err_o, 0);
      word_valid_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
      if (word_ready_o) begin
        check("load_cen", cen_o, exp_oh);
        check("load_shift", shift_o, 0);
        check("load_bit", cfg_bit_o, 0);
        if (stall_left > 0) begin
          stall_left--;
          start_i = 1'b1; col_i = '0; nbits_i = CNT_W'(5);
        end else begin
          w = (wi == 0) ? v.w0 : v.w1;
          wi++;
          word_i = w;
          word_valid_i = 1'b1;
          take = (bits_left < 32) ? bits_left : 32;
          for (int k = 0; k < take; k++) exp_q.push_back(w[k]);
          bits_left -= take;
        end
      end else if (shift_o != '0) begin
        check("shift_col", shift_o, exp_oh);
        check("shift_cen", cen_o, exp_oh);
        if (exp_q.size() == 0) check("sb_empty_bit", cfg_bit_o, 1'bx);
        else check("cfg_bit", cfg_bit_o, exp_q.pop_front());
        shift_cnt++;
        if (shift_cnt == v.abort_at) abort_i = 1'b1;
      end else if (set_o != '0) begin
        check("set_col", set_o, exp_oh);
        check("set_cen", cen_o, exp_oh);
        set_cnt++;
      end else if (done_o) begin
        check("done_cen", cen_o, 0);
        check("done_bit", cfg_bit_o, 0);
        done_cnt++;
      end else begin
        check("busy_without_phase", busy_o, 0);
      end
      tick();
    end
    word_valid_i = 1'b0; abort_i = 1'b0; start_i = 1'b0; col_i = '0; nbits_i = '0;

    exp_shift = (v.abort_at != 0) ? v.abort_at : (invalid ? 0 : v.nbits);
    check("timeout_busy", busy_o, 0);
    check("busy_cycles", busy_cnt, v.exp_busy);
    check("shift_cycles", shift_cnt, exp_shift);
    check("set_pulses", set_cnt, v.exp_set);
    check("done_pulses_busy", done_cnt, v.exp_set);
    check("end_err", err_o, v.exp_err);
    check("end_done", done_o, invalid);
    check("end_cen", cen_o, 0);
    check("end_ready", word_ready_o, 0);
    if (v.abort_at == 0) check("sb_leftover", exp_q.size(), 0);
    exp_q.delete();
    tick();
    check_quiet("after_txn_quiet");
  endtask

  initial begin
    //          col nbits  w0            w1            stall abort busy err set
    vecs[0] = '{2, 40, 32'hA5A5_A5A5, 32'h0000_00FF, 0, 0,  44, 1'b0, 1'b1};
    vecs[1] = '{0, 3,  32'hFFFF_FFF5, 32'h0000_0000, 0, 0,  6,  1'b0, 1'b1};
    vecs[2] = '{1, 0,  32'h1234_5678, 32'h0000_0000, 0, 0,  0,  1'b1, 1'b0};
    vecs[3] = '{5, 8,  32'h1234_5678, 32'h0000_0000, 0, 0,  0,  1'b1, 1'b0};
    vecs[4] = '{3, 64, 32'hDEAD_BEEF, 32'h1234_5678, 0, 10, 11, 1'b1, 1'b0};
    vecs[5] = '{4, 32, 32'h0F0F_1234, 32'h0000_0000, 7, 0,  42, 1'b0, 1'b1};
    vecs[6] = '{1, 33, 32'h8000_0001, 32'h0000_0001, 0, 0,  37, 1'b0, 1'b1};
    vecs[7] = '{4, 64, 32'h1357_9BDF, 32'h2468_ACE0, 0, 0,  68, 1'b0, 1'b1};

    #1;
    check_quiet("reset_state");
    tick();
    tick();
    wb_rst_ni = 1'b1;
    check_quiet("post_release_idle");

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset in the middle of a shift.
    start_i = 1'b1; col_i = COL_W'(2); nbits_i = CNT_W'(40);
    tick();
    start_i = 1'b0; col_i = '0; nbits_i = '0;
    word_valid_i = 1'b1; word_i = 32'hA5A5_A5A5;
    repeat (6) tick();
    check("pre_rst_busy", busy_o, 1);
    check("pre_rst_shift", shift_o, 5'b00100);
    #3 wb_rst_ni = 1'b0;
    #1;
    check_quiet("rst_async_quiet");
    word_valid_i = 1'b0;
    tick();
    tick();
    wb_rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_quiet("post_rst_no_done");
    end

    // Short reset pulse, then a start on the very first edge after release.
    wb_rst_ni = 1'b0;
    tick();
    wb_rst_ni = 1'b1;
    run_txn(vecs[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
